game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//   Top-level game sequencer. Produces the 3-bit game state consumed by the FND
//   elapsed-time display and by the game logic, and runs the start-up delay.
//   Also keeps a tick timer and forces DEFEAT on timeout, so the 3-digit
//   display never wraps past 999.
// PARAMETERS
//   INIT_CYC    50_000_000  cycles spent in INIT before PLAYING (0.5 s @100 MHz)
//   TICK_CYC    5_000_000   cycles per tick; equals the display timer rate (1/20 s)
//   TICK_LIMIT  999         tick count that triggers timeout DEFEAT (1..1023)
// PORTS
//   i_Clk        in   1   system clock, single domain
//   i_Rst        in   1   asynchronous, active-low reset
//   i_Start      in   1   start button level, already synchronised/debounced
//   i_Win        in   1   game logic: player won (level, sampled each cycle)
//   i_Lose       in   1   game logic: player lost
//   i_Err        in   1   game logic fault
//   i_Clear      in   1   acknowledge result/error, return to IDLE
//   o_GameState  out  3   IDLE=000 INIT=001 PLAYING=010 VICTORY=011 DEFEAT=100 ERROR=101
//   o_Tick       out  1   one-cycle pulse per elapsed tick in PLAYING
//   o_TickCnt    out  10  ticks elapsed in the current game
// BEHAVIOUR
//   Reset: o_GameState=000, o_Tick=0, o_TickCnt=0, counters=0, start-delay reg=1.
//     Start-delay reg=1 means a button held through reset gives no start.
//   Start edge = i_Start & ~start_d, where start_d is i_Start delayed one cycle.
//   All outputs are registered. A state change appears one cycle after the
//     cycle in which its condition is sampled.
//   IDLE: start edge -> INIT. Cycle and tick counters held at 0.
//   INIT: init counter counts 0..INIT_CYC-1. At INIT_CYC-1 -> PLAYING, so INIT
//     lasts exactly INIT_CYC cycles. i_Err -> ERROR. Start/Win/Lose ignored.
//   PLAYING: cycle counter counts 0..TICK_CYC-1 and wraps. On wrap, o_Tick=1
//     for one cycle and o_TickCnt increments by 1.
//     Exit priority, checked every cycle:
//       i_Err -> ERROR
//       i_Win -> VICTORY
//       i_Lose -> DEFEAT
//       tick increment that makes o_TickCnt == TICK_LIMIT -> DEFEAT
//     On a timeout, o_TickCnt=TICK_LIMIT and the state becomes DEFEAT on the
//       same edge. o_Tick still pulses.
//     On a Win/Lose/Err exit in the wrap cycle, that tick is dropped: no
//       increment, no o_Tick.
//   VICTORY/DEFEAT: counters and o_TickCnt frozen. i_Clear -> IDLE. Otherwise a
//     start edge -> INIT, with counters cleared. i_Clear has priority over start.
//   ERROR: counters cleared. Only i_Clear -> IDLE. Start edge ignored.
//   Illegal state codes 110/111 -> ERROR on the next edge.
//   Entering IDLE, INIT or ERROR clears the cycle counter, the init counter
//     and o_TickCnt.
//   Widths: the cycle counter is sized for TICK_CYC, the init counter for
//     INIT_CYC, and o_TickCnt never exceeds TICK_LIMIT.
//   Reset asserted mid-game returns everything to the reset values immediately.
// TESTING (INIT_CYC=4, TICK_CYC=3, TICK_LIMIT=5)
//   1. Release reset with i_Start=1 held -> state stays 000. Drop then raise
//      i_Start -> 001 next edge, 010 exactly 4 cycles later.
//   2. PLAYING 9 cycles, no inputs -> o_Tick pulses every 3rd cycle,
//      o_TickCnt=3, state 010.
//   3. Continue -> on the 5th tick o_TickCnt=5, state=100 same edge. Counters
//      frozen for 20 cycles. i_Clear -> 000 and o_TickCnt=0.
//   4. i_Win=1 and i_Lose=1 in the same cycle, on a wrap cycle at o_TickCnt=2
//      -> state 011, o_TickCnt stays 2, no o_Tick.
//   5. i_Err in INIT -> 101. Start edge -> stays 101. i_Clear -> 000.
//      i_Clear and start edge together in VICTORY -> 000.
//   6. Assert i_Rst low mid-PLAYING, between clock edges -> outputs 000/0/0
//      immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game sequencer: start-up delay, play tick timer with timeout, and result/error
// handling. Produces the 3-bit game state used by the display and game logic.
module game_state_ctrl #(
  parameter int INIT_CYC   = 50_000_000,
  parameter int TICK_CYC   = 5_000_000,
  parameter int TICK_LIMIT = 999
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Win,
  input  logic       i_Lose,
  input  logic       i_Err,
  input  logic       i_Clear,
  output logic [2:0] o_GameState,
  output logic       o_Tick,
  output logic [9:0] o_TickCnt
);

  // state   | meaning
  // IDLE    | waiting for a start edge, counters held at 0
  // INIT    | start-up delay of INIT_CYC cycles
  // PLAYING | game running, tick timer active
  // VICTORY | player won, counters frozen
  // DEFEAT  | player lost or timed out, counters frozen
  // ERROR   | game logic fault, waits for clear
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_INIT    = 3'b001,
    ST_PLAYING = 3'b010,
    ST_VICTORY = 3'b011,
    ST_DEFEAT  = 3'b100,
    ST_ERROR   = 3'b101
  } state_t;

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int CYC_W  = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_CYC - 1);
  localparam logic [9:0]        TICK_LIM  = 10'(TICK_LIMIT);

  state_t            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [9:0]        tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;
  logic              start_d_q, start_d_d;

  logic              start_edge;
  logic              wrap;
  logic              clr_cnt;
  logic [9:0]        tick_next;

  assign start_edge = i_Start & ~start_d_q;
  assign wrap       = (cyc_cnt_q == CYC_LAST);
  assign tick_next  = tick_cnt_q + 10'd1;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    start_d_d  = i_Start;
    clr_cnt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_cnt = 1'b1;
        if (start_edge) state_d = ST_INIT;
      end
      ST_INIT: begin
        if (i_Err) begin
          state_d = ST_ERROR;
          clr_cnt = 1'b1;
        end else if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_PLAYING;
          init_cnt_d = '0;
          cyc_cnt_d  = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_PLAYING: begin
        // A result exit on the wrap cycle drops that tick entirely.
        if (i_Err) begin
          state_d = ST_ERROR;
          clr_cnt = 1'b1;
        end else if (i_Win) begin
          state_d = ST_VICTORY;
        end else if (i_Lose) begin
          state_d = ST_DEFEAT;
        end else if (wrap) begin
          cyc_cnt_d  = '0;
          tick_d     = 1'b1;
          tick_cnt_d = tick_next;
          if (tick_next == TICK_LIM) state_d = ST_DEFEAT;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end
      ST_VICTORY, ST_DEFEAT: begin
        if (i_Clear) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end else if (start_edge) begin
          state_d = ST_INIT;
          clr_cnt = 1'b1;
        end
      end
      ST_ERROR: begin
        clr_cnt = 1'b1;
        if (i_Clear) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_ERROR;
        clr_cnt = 1'b1;
      end
    endcase

    if (clr_cnt) begin
      init_cnt_d = '0;
      cyc_cnt_d  = '0;
      tick_cnt_d = '0;
    end
  end

  // start_d resets to 1 so a button held through reset is not a start edge.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_IDLE;
      init_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      start_d_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      start_d_q  <= start_d_d;
    end
  end

  assign o_GameState = state_q;
  assign o_Tick      = tick_q;
  assign o_TickCnt   = tick_cnt_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus randomized play checked
// against an elapsed-time model of the game rules.
module tb_game_state_ctrl;

  localparam int INIT_CYC   = 4;
  localparam int TICK_CYC   = 3;
  localparam int TICK_LIMIT = 5;

  localparam int M_IDLE = 0, M_INIT = 1, M_PLAY = 2, M_VIC = 3, M_DEF = 4, M_ERR = 5;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_Start = 1'b0, i_Win = 1'b0, i_Lose = 1'b0, i_Err = 1'b0, i_Clear = 1'b0;
  logic [2:0] o_GameState;
  logic       o_Tick;
  logic [9:0] o_TickCnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time spent in each phase, ticks derived from elapsed play time.
  int m_state, m_init_elapsed, m_play_elapsed, m_ticks;
  bit m_tick, m_start_prev;

  game_state_ctrl #(.INIT_CYC(INIT_CYC), .TICK_CYC(TICK_CYC), .TICK_LIMIT(TICK_LIMIT)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Win(i_Win), .i_Lose(i_Lose),
    .i_Err(i_Err), .i_Clear(i_Clear), .o_GameState(o_GameState), .o_Tick(o_Tick),
    .o_TickCnt(o_TickCnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = M_IDLE; m_init_elapsed = 0; m_play_elapsed = 0; m_ticks = 0;
    m_tick = 0; m_start_prev = 1;
  endtask

  task automatic model_step(input bit s, input bit w, input bit l, input bit e, input bit c);
    bit pressed;
    pressed = s && !m_start_prev;
    m_start_prev = s;
    m_tick = 0;
    case (m_state)
      M_IDLE: if (pressed) begin m_state = M_INIT; m_init_elapsed = 0; end
      M_INIT: begin
        if (e) m_state = M_ERR;
        else begin
          m_init_elapsed++;
          if (m_init_elapsed == INIT_CYC) begin
            m_state = M_PLAY; m_play_elapsed = 0; m_ticks = 0;
          end
        end
      end
      M_PLAY: begin
        if (e) begin m_state = M_ERR; m_ticks = 0; end
        else if (w) m_state = M_VIC;
        else if (l) m_state = M_DEF;
        else begin
          m_play_elapsed++;
          if (m_play_elapsed % TICK_CYC == 0) begin
            m_tick = 1;
            m_ticks = m_play_elapsed / TICK_CYC;
            if (m_ticks == TICK_LIMIT) m_state = M_DEF;
          end
        end
      end
      M_VIC, M_DEF: begin
        if (c) begin m_state = M_IDLE; m_ticks = 0; end
        else if (pressed) begin m_state = M_INIT; m_init_elapsed = 0; m_ticks = 0; end
      end
      default: begin
        m_ticks = 0;
        if (c) m_state = M_IDLE;
      end
    endcase
  endtask

  task automatic step(input bit s, input bit w, input bit l, input bit e, input bit c);
    i_Start = s; i_Win = w; i_Lose = l; i_Err = e; i_Clear = c;
    @(posedge clk);
    model_step(s, w, l, e, c);
    #1;
  endtask

  task automatic test_reset();
    i_Rst = 1'b0; i_Start = 1'b1;
    #12;
    vectors += 3;
    if (o_GameState !== 3'b000) begin miscompares++; $display("FAIL reset_state got %b want 000", o_GameState); end
    if (o_Tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", o_Tick); end
    if (o_TickCnt !== 10'd0) begin miscompares++; $display("FAIL reset_tickcnt got %0d want 0", o_TickCnt); end
    i_Rst = 1'b1;
    model_reset();
  endtask

  task automatic test_start_delay();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      vectors++;
      if (o_GameState !== 3'b000) begin miscompares++; $display("FAIL held_start got %b want 000", o_GameState); end
    end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if (o_GameState !== 3'b001) begin miscompares++; $display("FAIL start_edge got %b want 001", o_GameState); end
    for (int i = 0; i < INIT_CYC; i++) begin
      step(0, 0, 0, 0, 0);
      vectors++;
      if (o_GameState !== ((i < INIT_CYC - 1) ? 3'b001 : 3'b010)) begin
        miscompares++; $display("FAIL init_len cycle %0d got %b", i, o_GameState);
      end
    end
  endtask

  task automatic test_ticks();
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 0);
      vectors++;
      if (o_Tick !== ((i % 3) == 2)) begin miscompares++; $display("FAIL tick_pulse cycle %0d got %b", i, o_Tick); end
    end
    vectors += 2;
    if (o_TickCnt !== 10'd3) begin miscompares++; $display("FAIL tickcnt9 got %0d want 3", o_TickCnt); end
    if (o_GameState !== 3'b010) begin miscompares++; $display("FAIL play9_state got %b want 010", o_GameState); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      vectors++;
      if (o_GameState !== ((i < 5) ? 3'b010 : 3'b100)) begin miscompares++; $display("FAIL timeout_state cycle %0d got %b", i, o_GameState); end
    end
    vectors += 2;
    if (o_TickCnt !== 10'd5) begin miscompares++; $display("FAIL timeout_cnt got %0d want 5", o_TickCnt); end
    if (o_Tick !== 1'b1) begin miscompares++; $display("FAIL timeout_tick got %b want 1", o_Tick); end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      vectors++;
      if (o_GameState !== 3'b100 || o_TickCnt !== 10'd5 || o_Tick !== 1'b0) begin
        miscompares++; $display("FAIL frozen cycle %0d got %b/%0d/%b want 100/5/0", i, o_GameState, o_TickCnt, o_Tick);
      end
    end
    step(0, 0, 0, 0, 1);
    vectors++;
    if (o_GameState !== 3'b000 || o_TickCnt !== 10'd0) begin
      miscompares++; $display("FAIL defeat_clear got %b/%0d want 000/0", o_GameState, o_TickCnt);
    end
  endtask

  task automatic test_win_lose_wrap();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < INIT_CYC; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    vectors++;
    if (o_TickCnt !== 10'd2) begin miscompares++; $display("FAIL pre_wrap_cnt got %0d want 2", o_TickCnt); end
    step(0, 1, 1, 0, 0);
    vectors++;
    if (o_GameState !== 3'b011 || o_TickCnt !== 10'd2 || o_Tick !== 1'b0) begin
      miscompares++; $display("FAIL win_on_wrap got %b/%0d/%b want 011/2/0", o_GameState, o_TickCnt, o_Tick);
    end
  endtask

  task automatic test_error();
    step(1, 0, 0, 0, 1);
    vectors++;
    if (o_GameState !== 3'b000) begin miscompares++; $display("FAIL clear_over_start got %b want 000", o_GameState); end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    vectors++;
    if (o_GameState !== 3'b101) begin miscompares++; $display("FAIL init_err got %b want 101", o_GameState); end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if (o_GameState !== 3'b101) begin miscompares++; $display("FAIL err_start got %b want 101", o_GameState); end
    step(0, 0, 0, 0, 1);
    vectors++;
    if (o_GameState !== 3'b000) begin miscompares++; $display("FAIL err_clear got %b want 000", o_GameState); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < INIT_CYC + 4; i++) step(0, 0, 0, 0, 0);
    vectors++;
    if (o_GameState !== 3'b010 || o_TickCnt !== 10'd1) begin
      miscompares++; $display("FAIL pre_reset got %b/%0d want 010/1", o_GameState, o_TickCnt);
    end
    #3 i_Rst = 1'b0;
    #1;
    vectors++;
    if (o_GameState !== 3'b000 || o_Tick !== 1'b0 || o_TickCnt !== 10'd0) begin
      miscompares++; $display("FAIL async_reset got %b/%b/%0d want 000/0/0", o_GameState, o_Tick, o_TickCnt);
    end
    #3 i_Rst = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit s, w, l, e, c;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 127) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(s, w, l, e, c);
      vectors += 3;
      if (o_GameState !== 3'(m_state)) begin miscompares++; $display("FAIL rnd_state cycle %0d got %b want %0d", i, o_GameState, m_state); end
      if (o_Tick !== m_tick) begin miscompares++; $display("FAIL rnd_tick cycle %0d got %b want %b", i, o_Tick, m_tick); end
      if (o_TickCnt !== 10'(m_ticks)) begin miscompares++; $display("FAIL rnd_tickcnt cycle %0d got %0d want %0d", i, o_TickCnt, m_ticks); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_delay();
    test_ticks();
    test_timeout();
    test_win_lose_wrap();
    test_error();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
